// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants and types for the sync_fifo_ctrl line/sample buffer.
// Covers the pointer width helper, the output-buffer states and the default widths.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 7;

    // One extra MSB so a full memory and an empty memory give different pointer differences.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_TWO   = 2'd2
    } ob_state_e;

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sync_fifo_ctrl.
// The FIFO uses the slave view; whoever feeds and drains it uses the master view.
interface sync_fifo_ctrl_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sram.sv
// Simple dual-port memory with a registered read port (1-cycle latency).
// A read that hits the address being written in the same cycle returns the old contents.
module sram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk_wr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_ptr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clk_rd,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [DATA_WIDTH-1:0] data_out
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_wr) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_rd) begin
        if (rd_en) data_out <= mem[rd_ptr];
    end
endmodule

// File: rtl/sync_fifo_ctrl_out_buf.sv
// Two-entry first-word-fall-through buffer that sits behind the sram read port.
// The head entry is presented directly, so out_data stays put until it is popped.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_i,
    output logic [1:0]            cnt_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    ob_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] entry_q [2];
    logic                  head_q;
    logic                  tail_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            OB_EMPTY: if (wr_i) state_d = OB_ONE;
            OB_ONE: begin
                if (wr_i && !rd_i)      state_d = OB_TWO;
                else if (!wr_i && rd_i) state_d = OB_EMPTY;
            end
            OB_TWO:   if (rd_i && !wr_i) state_d = OB_ONE;
            default:  state_d = OB_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OB_EMPTY;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            entry_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            if (wr_i) begin
                entry_q[tail_q] <= wr_data_i;
                tail_q          <= ~tail_q;
            end
            if (rd_i) head_q <= ~head_q;
        end
    end

    assign cnt_o   = state_q;
    assign valid_o = (state_q != OB_EMPTY);
    assign data_o  = entry_q[head_q];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// FIFO controller wrapping the dual-port sram: pointer/occupancy tracking, read scheduling
// into a 2-entry output buffer, and valid/ready handshakes on both sides.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = 120
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sync_fifo_ctrl_if.slave       bus,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);
    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int CNT_W = ADDR_WIDTH + 2;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      mem_cnt;
    logic                  rd_inflight_q;
    logic [1:0]            ob_cnt;
    logic [2:0]            ob_occ;
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic                  push, pop, rd_en;

    assign mem_cnt      = wr_ptr_q - rd_ptr_q;
    assign full         = (mem_cnt == PTR_W'(DEPTH));
    assign bus.in_ready = rst_n && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.out_valid && bus.out_ready;

    // Only fetch when the word is guaranteed a slot in the output buffer when it lands.
    assign ob_occ = {1'b0, ob_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop};
    assign rd_en  = (mem_cnt != '0) && (ob_occ < 3'd2);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_inflight_q <= rd_en;
        end
    end

    sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk_wr   (clk),
        .wr_en    (push),
        .wr_ptr   (wr_ptr_q[ADDR_WIDTH-1:0]),
        .data_in  (bus.in_data),
        .clk_rd   (clk),
        .rd_en    (rd_en),
        .rd_ptr   (rd_ptr_q[ADDR_WIDTH-1:0]),
        .data_out (sram_rdata)
    );

    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (rd_inflight_q),
        .wr_data_i (sram_rdata),
        .rd_i      (pop),
        .cnt_o     (ob_cnt),
        .valid_o   (bus.out_valid),
        .data_o    (bus.out_data)
    );

    assign count       = CNT_W'(mem_cnt) + CNT_W'(rd_inflight_q) + CNT_W'(ob_cnt);
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_W'(AF_LEVEL));
endmodule
